// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle between the operand stage, the shift sequencer and the result mux.
// The slave modport is the sequencer's view; the master modport is the requester/consumer's view.
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport master (
    output in_valid, in_data, in_amt, in_dir, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-position logical shift built by iterating an external 1-bit shifter: amt edges from accept to result,
// accepts only when idle, holds the result stable in DONE until out_ready.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_sequencer_if.slave bus,
  output logic [WIDTH-1:0] sh_a_o,
  input  logic [WIDTH-1:0] sh_left_i,
  input  logic [WIDTH-1:0] sh_right_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             carry_q, carry_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d   = bus.in_data;
          cnt_d   = bus.in_amt;
          dir_d   = bus.in_dir;
          carry_d = 1'b0;
          state_d = (bus.in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // No early exit once acc reaches zero: the count always runs to completion.
        acc_d   = dir_q ? sh_right_i : sh_left_i;
        carry_d = dir_q ? acc_q[0] : acc_q[WIDTH-1];
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sh_a_o        = acc_q;
  assign bus.out_data  = acc_q;
  assign bus.out_carry = carry_q;
  assign bus.out_zero  = (acc_q == '0);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural 1-bit shifter, scoreboard of expected results per request.
// Directed cases, backpressure, async reset mid-shift and a randomized back-to-back stream.
module tb_shift_sequencer;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             zero;
    int               lat;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_left;
  logic [WIDTH-1:0] sh_right;
  logic             busy;

  exp_t exp_q[$];
  int   vec;
  int   errs;

  shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .sh_a_o     (sh_a),
    .sh_left_i  (sh_left),
    .sh_right_i (sh_right),
    .busy_o     (busy)
  );

  assign sh_left  = sh_a << 1;
  assign sh_right = sh_a >> 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] d, input int amt, input logic dir);
    exp_t e;
    e.data  = d;
    e.carry = 1'b0;
    for (int i = 0; i < amt; i++) begin
      e.carry = dir ? e.data[0] : e.data[WIDTH-1];
      e.data  = dir ? (e.data >> 1) : (e.data << 1);
    end
    e.zero = (e.data == '0);
    e.lat  = amt;
    return e;
  endfunction

  // Drives one request, waits for in_ready, then counts edges from accept until out_valid.
  task automatic send(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] amt, input logic dir,
                      output int edges);
    int waits;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = amt;
    bus.in_dir   = dir;
    waits = 0;
    while (!bus.in_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    bus.in_amt   = ~amt;
    bus.in_dir   = ~dir;
    edges = 0;
    while (!bus.out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    vec++;
    if ({bus.in_ready, bus.out_valid, bus.out_carry, bus.out_zero, busy, bus.out_data, sh_a} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000}) begin
      errs++;
      $display("FAIL reset_state got rdy=%b vld=%b c=%b z=%b busy=%b d=%h exp rdy=1 vld=0 c=0 z=1 busy=0 d=0000",
               bus.in_ready, bus.out_valid, bus.out_carry, bus.out_zero, busy, bus.out_data);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] d_t[6]   = '{16'h8001, 16'h8001, 16'h1234, 16'h1234, 16'hFFFF, 16'h0001};
    logic [AMT_W-1:0] a_t[6]   = '{4'd1, 4'd4, 4'd0, 4'd0, 4'd15, 4'd15};
    logic             r_t[6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [WIDTH-1:0] ed_t[6]  = '{16'h0002, 16'h0800, 16'h1234, 16'h1234, 16'h8000, 16'h0000};
    logic             ec_t[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int edges;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{ed_t[i], ec_t[i], (ed_t[i] == '0), int'(a_t[i])});
      send(d_t[i], a_t[i], r_t[i], edges);
      e = exp_q.pop_front();
      vec++;
      if (edges != e.lat) begin
        errs++;
        $display("FAIL directed%0d_latency got %0d edges exp %0d", i, edges, e.lat);
      end
      vec++;
      if ({bus.out_valid, bus.out_data, bus.out_carry, bus.out_zero, busy} !== {1'b1, e.data, e.carry, e.zero, 1'b1}) begin
        errs++;
        $display("FAIL directed%0d_result got vld=%b d=%h c=%b z=%b exp vld=1 d=%h c=%b z=%b",
                 i, bus.out_valid, bus.out_data, bus.out_carry, bus.out_zero, e.data, e.carry, e.zero);
      end
      drain();
      vec++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
        errs++;
        $display("FAIL directed%0d_release got rdy=%b vld=%b exp rdy=1 vld=0", i, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int edges;
    exp_t e;
    exp_q.push_back('{16'h0780, 1'b0, 1'b0, 3});
    send(16'h00F0, 4'd3, 1'b0, edges);
    e = exp_q.pop_front();
    vec++;
    if (edges != e.lat) begin
      errs++;
      $display("FAIL bp_latency got %0d edges exp %0d", edges, e.lat);
    end
    // A competing request during DONE must be ignored.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h5555;
    bus.in_amt   = 4'd2;
    bus.in_dir   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      vec++;
      if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_carry} !== {1'b1, 1'b0, e.data, e.carry}) begin
        errs++;
        $display("FAIL bp_hold%0d got vld=%b rdy=%b d=%h c=%b exp vld=1 rdy=0 d=%h c=%b",
                 c, bus.out_valid, bus.in_ready, bus.out_data, bus.out_carry, e.data, e.carry);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain();
    vec++;
    if ({bus.in_ready, bus.out_valid, busy} !== 3'b100) begin
      errs++;
      $display("FAIL bp_release got rdy=%b vld=%b busy=%b exp rdy=1 vld=0 busy=0", bus.in_ready, bus.out_valid, busy);
    end
  endtask

  task automatic test_async_reset();
    int edges;
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hABCD;
    bus.in_amt   = 4'd8;
    bus.in_dir   = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{16'h0000, 1'b1, 1'b1, 8});
    send(16'h00FF, 4'd8, 1'b1, edges);
    e = exp_q.pop_front();
    vec++;
    if (edges != e.lat || {bus.out_data, bus.out_carry, bus.out_zero} !== {e.data, e.carry, e.zero}) begin
      errs++;
      $display("FAIL post_reset_req got lat=%0d d=%h c=%b z=%b exp lat=%0d d=%h c=%b z=%b",
               edges, bus.out_data, bus.out_carry, bus.out_zero, e.lat, e.data, e.carry, e.zero);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int edges;
    exp_t e;
    logic [WIDTH-1:0] d;
    logic [AMT_W-1:0] a;
    logic             r;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = WIDTH'($urandom);
      a = AMT_W'($urandom_range(0, 15));
      r = 1'($urandom);
      exp_q.push_back(model(d, int'(a), r));
      send(d, a, r, edges);
      e = exp_q.pop_front();
      vec++;
      if (edges != e.lat || {bus.out_data, bus.out_carry, bus.out_zero} !== {e.data, e.carry, e.zero}) begin
        errs++;
        $display("FAIL b2b%0d in=%h amt=%0d dir=%b got lat=%0d d=%h c=%b z=%b exp lat=%0d d=%h c=%b z=%b",
                 i, d, a, r, edges, bus.out_data, bus.out_carry, bus.out_zero, e.lat, e.data, e.carry, e.zero);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_directed();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
